hex_display_scanner: RTL
========================

Name: hex_display_scanner

Overview:
- Time-multiplexed controller for a bank of common-anode 7-segment digits sharing one segment bus.
- Holds a multi-digit hex value and scans one digit at a time through one internal HEXto7Segment decoder instance.
- Inserts a dead-time gap between digits, accepts new values over a valid/ready handshake, and commits them only on frame boundaries so no tearing is visible.
- Sits between the processor's debug/register-out path and the FPGA display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; value width is 4*NUM_DIGITS.
- SCAN_DIV, 1024: clock cycles each digit is lit (>=1).
- GAP_CYCLES, 16: clock cycles with all anodes off between digits (0 = no gap).
- BLINK_BITS, 6: frame-count width for the blink period (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- load_valid  in  1  new value offered.
- load_data  in  4*NUM_DIGITS  value to display, nibble i drives digit i (digit 0 = least significant).
- load_ready  out  1  scanner can accept a value.
- lz_en  in  1  leading-zero blanking enable.
- blink  in  1  blink request (ignored unless BLINK_EN is defined).
- digit_an  out  NUM_DIGITS  active-low one-hot anode select.
- seg  out  7  active-low segments, {g,f,e,d,c,b,a} = seg[6:0].
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset is asynchronous on resetn low:
  - digit_an = all 1s, seg = 7'h7F, load_ready = 1, frame_tick = 0.
  - Shadow value = 0, pending flag = 0, digit index = 0, counter = 0, state = SHOW.
- FSM states:
  - SHOW: counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 the counter clears and the FSM goes to GAP (or straight to ADVANCE if GAP_CYCLES = 0).
  - GAP: all anodes off; counts 0..GAP_CYCLES-1, then goes to ADVANCE.
  - ADVANCE: single cycle. Index increments and wraps NUM_DIGITS-1 -> 0; the FSM returns to SHOW.
- Frame boundary is the ADVANCE cycle that wraps the index to 0. In that cycle:
  - frame_tick = 1 (registered, visible the cycle after ADVANCE).
  - If pending, shadow <= buffer and pending <= 0.
- Frame length = NUM_DIGITS*(SCAN_DIV + GAP_CYCLES + 1) cycles.
- Handshake:
  - load_ready = !pending (registered).
  - A transfer occurs when load_valid && load_ready at a clock edge: buffer <= load_data, pending <= 1.
  - If a transfer lands in the frame-boundary cycle, it is not committed in that cycle; it waits for the next boundary.
  - load_data is ignored whenever load_ready = 0.
- Outputs are registered, one cycle after the state/index that produces them:
  - SHOW: digit_an = ~(1 << index), seg = decode(shadow nibble[index]).
  - GAP and ADVANCE: digit_an = all 1s, seg = 7'h7F.
- Leading-zero blanking: with lz_en = 1, digit i > 0 is blanked when nibbles NUM_DIGITS-1 down to i of the shadow are all zero.
  - A blanked digit has its anode held off and seg = 7'h7F for the full SHOW slot; timing is unchanged.
  - Digit 0 is never blanked.
- lz_en is sampled every cycle; no synchronisation is required (static configuration input).
- Reset mid-operation (any state) drops the pending value and the shadow value. Scanning restarts at digit 0 in SHOW on the first edge after resetn rises.

Optional Feature:
- Macro: HEX_DISPLAY_SCANNER_BLINK_EN.
- Defined: a BLINK_BITS-wide frame counter increments on each frame boundary.
  - While blink = 1 and the counter MSB = 1, all anodes are forced off and seg = 7'h7F.
  - Scan timing and the handshake are unaffected; when blink = 0 the display is always on.
  - The counter resets to 0.
- Not defined: no counter exists, the blink port is ignored, and the display is never forced off.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, GAP_CYCLES=2, frame = 44 cycles):
- Reset check: assert resetn=0 mid-SHOW -> same time step digit_an=4'b1111, seg=7'h7F, load_ready=1; first SHOW after release has digit_an=4'b1110, seg=7'b1000000 ("0").
- Mid-frame load: load 16'h12AF at cycle 10 -> load_ready=0 next cycle; old value continues until frame_tick; next frame gives digit0 seg=7'b0001110 (F), digit3 seg=7'b1111001 (1); load_ready returns to 1.
- Leading zeros: lz_en=1, value 16'h0005 -> digits 3..1 show anode off and seg=7'h7F; digit0 shows digit_an=4'b1110, seg=7'b0010010 (5). With 16'h0000 only digit0 shows "0".
- Back-to-back loads: load_valid held high with 16'h1111 then 16'h2222 -> the second transfer occurs only after the boundary that commits 16'h1111; each value is displayed for at least one full frame.
- Gap timing: measure one digit -> anode low for exactly 8 cycles, then all anodes high for 3 cycles (2 GAP + 1 ADVANCE); frame_tick period is 44 cycles.
- Blink (macro defined, BLINK_BITS=2): blink=1 -> display alternates 2 frames on / 2 frames off; blink=0 -> always on.

Source files
------------

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed driver for a bank of common-anode 7-segment digits.
// Optional blink gating is compiled in when HEX_DISPLAY_SCANNER_BLINK_EN is defined.
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024,
  parameter int GAP_CYCLES = 16,
  parameter int BLINK_BITS = 6
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    lz_en,
  input  logic                    blink,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic [6:0]              seg,
  output logic                    frame_tick
);
  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam bit               NO_GAP    = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {SHOW, GAP, ADVANCE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [VAL_W-1:0]   shadow, buffer;
  logic               pending, pending_n;
  logic               xfer, boundary, blank, force_off;
  logic [3:0]         nibble;
  logic [NUM_DIGITS-1:0] an_n;
  logic [6:0]         seg_n;

  function automatic logic [6:0] hex_to_7seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign xfer      = load_valid && load_ready;
  assign boundary  = (state == ADVANCE) && (idx == IDX_LAST);
  // Transfers and commits are mutually exclusive: a transfer needs pending low, a commit needs it high.
  assign pending_n = xfer ? 1'b1 : (boundary ? 1'b0 : pending);
  assign nibble    = shadow[{idx, 2'b00} +: 4];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    case (state)
      SHOW: begin
        if (cnt == SCAN_LAST) begin
          cnt_n   = '0;
          state_n = NO_GAP ? ADVANCE : GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = ADVANCE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        state_n = SHOW;
      end
    endcase
  end

  // A digit is blanked only when it and every more significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    if (lz_en && (idx != '0)) begin
      blank = 1'b1;
      for (int j = 1; j < NUM_DIGITS; j++) begin
        if ((j >= int'(idx)) && (shadow[4*j +: 4] != 4'h0)) blank = 1'b0;
      end
    end
  end

  always_comb begin
    an_n  = '1;
    seg_n = 7'h7F;
    if ((state == SHOW) && !blank && !force_off) begin
      an_n  = ~(NUM_DIGITS'(1) << idx);
      seg_n = hex_to_7seg(nibble);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= SHOW;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      buffer     <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      frame_tick <= 1'b0;
      digit_an   <= '1;
      seg        <= 7'h7F;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      frame_tick <= boundary;
      if (xfer) buffer <= load_data;
      if (boundary && pending) shadow <= buffer;
      pending    <= pending_n;
      load_ready <= !pending_n;
      digit_an   <= an_n;
      seg        <= seg_n;
    end
  end

`ifdef HEX_DISPLAY_SCANNER_BLINK_EN
  logic [BLINK_BITS-1:0] frame_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       frame_cnt <= '0;
    else if (boundary) frame_cnt <= frame_cnt + 1'b1;
  end

  assign force_off = blink && frame_cnt[BLINK_BITS-1];
`else
  logic unused_blink;
  assign unused_blink = blink & (BLINK_BITS > 0);
  assign force_off    = 1'b0;
`endif

endmodule
